// File: rtl/bcd_timer_ctrl_if.sv
// Command/status bundle between front-panel logic and the BCD timer.
// Width of the count bus follows DIGITS.
interface bcd_timer_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  up_d;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   cnt;
    logic [1:0]            state;
    logic                  running;
    logic                  tc;
    logic                  done;

    modport master (
        output start, stop, up_d, load, load_val,
        input  cnt, state, running, tc, done
    );

    modport slave (
        input  start, stop, up_d, load, load_val,
        output cnt, state, running, tc, done
    );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Prescaled BCD up/down timer: digit cascade, run/pause/done sequencing.
// All state updates on the falling clock edge.
module bcd_timer_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic             clk,
    input  logic             clr_n,
    bcd_timer_ctrl_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [4*DIGITS-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0]       r_pre, w_pre_nxt;
    logic                r_done, w_done_nxt;

    logic [DIGITS-1:0]   w_term;
    logic [DIGITS:0]     w_chain;
    logic [4*DIGITS-1:0] w_step;
    logic [4*DIGITS-1:0] w_clamp;
    logic                w_tick;
    logic                w_tc;

    // Per-digit terminal flags drive both tc and the carry/borrow chain.
    always_comb begin
        w_term  = '0;
        w_chain = '0;
        w_step  = r_cnt;
        w_clamp = '0;
        w_chain[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_term[i] = bus.up_d ? (r_cnt[4*i +: 4] == 4'd9)
                                 : (r_cnt[4*i +: 4] == 4'd0);
            w_chain[i+1] = w_chain[i] & w_term[i];
            if (w_chain[i]) begin
                if (bus.up_d)
                    w_step[4*i +: 4] = w_term[i] ? 4'd0
                                     : r_cnt[4*i +: 4] + 4'd1;
                else
                    w_step[4*i +: 4] = w_term[i] ? 4'd9
                                     : r_cnt[4*i +: 4] - 4'd1;
            end
            w_clamp[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9
                              : bus.load_val[4*i +: 4];
        end
    end

    assign w_tc   = &w_term;
    assign w_tick = (r_pre == PMAX);

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pre   <= w_pre_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pre_nxt   = r_pre;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.load) begin
                    w_cnt_nxt = w_clamp;
                end else if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_pre_nxt   = '0;
                end
            end
            S_RUN: begin
                // stop beats a coincident tick: prescaler phase is frozen
                if (bus.stop) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_tick) begin
                    w_pre_nxt = '0;
                    if (w_tc) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_step;
                    end
                end else begin
                    w_pre_nxt = r_pre + PW'(1);
                end
            end
            S_PAUSE: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                    w_pre_nxt   = '0;
                end else if (bus.load) begin
                    w_cnt_nxt = w_clamp;
                end else if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.load) begin
                    w_cnt_nxt   = w_clamp;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.cnt     = r_cnt;
    assign bus.state   = r_state;
    assign bus.running = (r_state == S_RUN);
    assign bus.tc      = w_tc;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl with DIGITS=2, PRESCALE=4.
// Inputs change and outputs are sampled 2 time units after each falling edge.
module tb_bcd_timer_ctrl;
    logic clk = 1'b1;
    logic clr_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bcd_timer_ctrl_if #(.DIGITS(2)) bus ();

    bcd_timer_ctrl #(
        .DIGITS  (2),
        .PRESCALE(4)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] c,
                          input logic [1:0] s);
        chk({tag, ".cnt"}, 32'(bus.cnt), 32'(c));
        chk({tag, ".state"}, 32'(bus.state), 32'(s));
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.up_d = 0;
        bus.load = 0; bus.load_val = 8'h00;
        #3;
        chk_st("reset", 8'h00, 2'b00);
        chk("reset.done", 32'(bus.done), 0);
        chk("reset.running", 32'(bus.running), 0);
        chk("reset.tc_down", 32'(bus.tc), 1);
        cyc(2);
        clr_n = 1'b1;
        cyc(1);

        // up cascade 08 -> 09 -> 10
        bus.up_d = 1; bus.load = 1; bus.load_val = 8'h08;
        cyc(1);
        chk_st("up_load", 8'h08, 2'b00);
        bus.load = 0; bus.start = 1;
        cyc(1);
        bus.start = 0;
        chk("up_running", 32'(bus.running), 1);
        cyc(3);
        chk_st("up_pre3", 8'h08, 2'b01);
        cyc(1);
        chk_st("up_tick1", 8'h09, 2'b01);
        cyc(4);
        chk_st("up_tick2", 8'h10, 2'b01);
        chk("up_running2", 32'(bus.running), 1);
        bus.stop = 1;
        cyc(1);
        chk_st("up_pause", 8'h10, 2'b10);
        cyc(1);
        chk_st("up_idle", 8'h10, 2'b00);
        bus.stop = 0;

        // up terminal 98 -> 99 -> DONE
        bus.load = 1; bus.load_val = 8'h98;
        cyc(1);
        bus.load = 0; bus.start = 1;
        cyc(1);
        bus.start = 0;
        cyc(4);
        chk_st("term_tick1", 8'h99, 2'b01);
        chk("term_tc", 32'(bus.tc), 1);
        chk("term_nodone", 32'(bus.done), 0);
        cyc(3);
        chk_st("term_pre3", 8'h99, 2'b01);
        cyc(1);
        chk_st("term_done", 8'h99, 2'b11);
        chk("term_done_pulse", 32'(bus.done), 1);
        cyc(1);
        chk("term_done_clear", 32'(bus.done), 0);
        bus.start = 1;
        cyc(2);
        chk_st("term_start_ign", 8'h99, 2'b11);
        chk("term_done_low", 32'(bus.done), 0);
        bus.start = 0; bus.stop = 1;
        cyc(1);
        chk_st("term_stop", 8'h99, 2'b00);
        bus.stop = 0;

        // down with borrow 10 -> 09
        bus.up_d = 0; bus.load = 1; bus.load_val = 8'h10;
        cyc(1);
        bus.load = 0; bus.start = 1;
        cyc(1);
        bus.start = 0;
        cyc(4);
        chk_st("dn_borrow", 8'h09, 2'b01);
        bus.stop = 1;
        cyc(1);
        bus.stop = 0; bus.load = 1; bus.load_val = 8'h01;
        cyc(1);
        chk_st("pause_load", 8'h01, 2'b10);
        bus.load = 0; bus.stop = 1;
        cyc(1);
        bus.stop = 0; bus.start = 1;
        cyc(1);
        bus.start = 0;
        chk_st("dn_start", 8'h01, 2'b01);
        cyc(4);
        chk_st("dn_zero", 8'h00, 2'b01);
        cyc(4);
        chk_st("dn_done", 8'h00, 2'b11);
        chk("dn_done_pulse", 32'(bus.done), 1);
        cyc(1);
        chk("dn_done_clear", 32'(bus.done), 0);
        bus.load = 1; bus.load_val = 8'hFA;
        cyc(1);
        chk_st("done_load_clamp", 8'h99, 2'b00);
        bus.load_val = 8'h3F;
        cyc(1);
        chk_st("idle_load_clamp", 8'h39, 2'b00);
        bus.load = 0;

        // pause/resume keeps prescaler phase
        bus.up_d = 1; bus.load = 1; bus.load_val = 8'h00;
        cyc(1);
        bus.load = 0; bus.start = 1;
        cyc(1);
        bus.start = 0;
        cyc(4);
        chk_st("pr_tick", 8'h01, 2'b01);
        cyc(2);
        bus.stop = 1;
        cyc(1);
        bus.stop = 0;
        chk_st("pr_pause", 8'h01, 2'b10);
        cyc(10);
        chk_st("pr_frozen", 8'h01, 2'b10);
        bus.start = 1;
        cyc(1);
        bus.start = 0;
        chk_st("pr_resume", 8'h01, 2'b01);
        cyc(1);
        chk_st("pr_resume1", 8'h01, 2'b01);
        cyc(1);
        chk_st("pr_resume2", 8'h02, 2'b01);
        bus.stop = 1;
        cyc(2);
        bus.stop = 0;
        chk_st("pr_idle", 8'h02, 2'b00);

        // command conflicts, load ignored in RUN, direction change
        bus.start = 1; bus.stop = 1;
        cyc(1);
        chk_st("conflict", 8'h02, 2'b00);
        bus.start = 0; bus.stop = 0;
        bus.load = 1; bus.load_val = 8'h43;
        cyc(1);
        bus.load = 0; bus.start = 1;
        cyc(1);
        bus.start = 0;
        cyc(4);
        chk_st("dir_44", 8'h44, 2'b01);
        bus.load = 1; bus.load_val = 8'h00;
        cyc(4);
        bus.load = 0;
        chk_st("run_load_ign", 8'h45, 2'b01);
        bus.up_d = 0;
        cyc(4);
        chk_st("dir_change", 8'h44, 2'b01);
        chk("dir_tc", 32'(bus.tc), 0);
        bus.stop = 1;
        cyc(2);
        bus.stop = 0;

        // start at terminal: DONE on the first tick, no count
        bus.up_d = 1; bus.load = 1; bus.load_val = 8'h99;
        cyc(1);
        bus.load = 0; bus.start = 1;
        cyc(1);
        bus.start = 0;
        cyc(4);
        chk_st("tc_start", 8'h99, 2'b11);
        chk("tc_start_done", 32'(bus.done), 1);
        bus.stop = 1;
        cyc(1);
        bus.stop = 0;

        // async reset mid-RUN
        bus.load = 1; bus.load_val = 8'h36;
        cyc(1);
        bus.load = 0; bus.start = 1;
        cyc(1);
        bus.start = 0;
        cyc(4);
        chk_st("rst_pre", 8'h37, 2'b01);
        #1 clr_n = 1'b0;
        #1;
        chk_st("rst_async", 8'h00, 2'b00);
        chk("rst_done", 32'(bus.done), 0);
        bus.start = 1;
        cyc(2);
        chk_st("rst_held", 8'h00, 2'b00);
        bus.start = 0;
        clr_n = 1'b1;
        cyc(1);
        bus.start = 1;
        cyc(1);
        bus.start = 0;
        chk_st("rst_restart", 8'h00, 2'b01);
        cyc(3);
        chk_st("rst_pre3", 8'h00, 2'b01);
        cyc(1);
        chk_st("rst_tick", 8'h01, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
Sequencing controller for a chain of mod-10 up/down digit counters, forming a DIGITS-wide BCD timer/stopwatch.
- Generates the count tick from a clock prescaler and cascades digit carries/borrows.
- Handles start/stop/pause/load commands.
- Stops at terminal count (all 9s up, all 0s down) and issues a one-cycle done pulse.
- Sits between front-panel command logic and the BCD display path.

Parameters:
DIGITS, 4, number of BCD digits in the chain (1..8)
PRESCALE, 10, clk cycles per count tick (>=1)

Ports:
clk  input  1  clock; all flops update on the falling edge
clr_n  input  1  reset, asynchronous, active-low
start  input  1  run/resume request, level sampled each edge
stop  input  1  pause/abort request, level sampled each edge
up_d  input  1  direction: 1 = count up, 0 = count down
load  input  1  load request
load_val  input  4*DIGITS  preset value, digit i at [4i+3:4i]
cnt  output  4*DIGITS  current BCD count
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
running  output  1  high when state == RUN
tc  output  1  combinational; all digits 9 (up_d=1) or all digits 0 (up_d=0)
done  output  1  registered one-cycle pulse on entry to DONE

Behaviour:
- Reset (clr_n low, async):
  - cnt = 0, state = IDLE, prescaler = 0, done = 0.
  - Takes effect immediately, including mid-RUN; all outputs stay held while clr_n is low.
- Command priority in every state: stop > load > start.
- IDLE:
  - load -> cnt <= load_val, with any digit > 9 clamped to 9; state stays IDLE.
  - start (without stop) -> RUN; prescaler cleared to 0.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps; tick = (prescaler == PRESCALE-1).
  - First tick lands on the PRESCALE-th falling edge after the edge that entered RUN.
  - load and start are ignored in RUN.
  - stop -> PAUSE; prescaler holds its value; stop has priority over a coincident tick, so no count on that edge.
- Tick, not terminal:
  - Digit 0 steps every tick; digit i steps only when digits 0..i-1 are all at terminal (9 up, 0 down).
  - Each digit wraps mod 10: 9 -> 0 up, 0 -> 9 down.
- Tick at terminal (tc = 1):
  - No wrap; cnt holds; state -> DONE; done = 1 for exactly one cycle.
- up_d is sampled at every tick; a direction change mid-RUN takes effect at the next tick. tc follows up_d combinationally.
- PAUSE:
  - cnt and prescaler hold.
  - start -> RUN, resuming the prescaler phase (no restart).
  - stop -> IDLE, prescaler cleared, cnt held.
  - load -> cnt <= clamped load_val; state stays PAUSE.
- DONE:
  - cnt holds; start is ignored.
  - stop -> IDLE.
  - load -> cnt <= clamped load_val and state -> IDLE.
- Starting from IDLE with cnt already at terminal: enter RUN, reach DONE on the first tick with no count change.
- PRESCALE = 1: tick on every RUN cycle.
- Arithmetic: per-digit 4-bit BCD only; no binary intermediate; cnt never holds a digit > 9.

Test Plan:
(All scenarios use DIGITS=2, PRESCALE=4.)
- Up cascade: load 0x08, up_d=1, start pulse -> cnt 0x09 at the 4th falling edge after start, 0x10 at the 8th; running=1 throughout.
- Up terminal: load 0x98, start -> 0x99 after the 1st tick; at the 2nd tick state=11, done high exactly one cycle, cnt stays 0x99, tc=1; later start is ignored; stop -> IDLE.
- Down / borrow: load 0x10, up_d=0, start -> 0x09 at the 4th edge. Separately: load 0x01 -> 0x00 at the 1st tick, DONE at the 2nd tick, done pulses once.
- Pause/resume: run from 0x00, assert stop 2 edges after a tick -> PAUSE, cnt frozen for 10 cycles; start -> next tick exactly 2 edges later (phase kept); stop in PAUSE -> IDLE, cnt held.
- Command conflicts and clamp:
  - start+stop together in IDLE -> stays IDLE.
  - load 0xFA in IDLE -> cnt 0x99.
  - load during RUN -> ignored, counting continues.
  - up_d toggled 1->0 mid-RUN at 0x45 -> next tick gives 0x44.
- Reset mid-operation: RUN at cnt 0x37, drop clr_n between edges -> cnt 0x00, state 00, done 0 immediately. Release clr_n, then start -> first count after 4 edges.
